// File: rtl/div3_recon_if.sv
// Handshake bundle for the divide-by-3 reconstruction unit.
// The ports under DIV3_RECON_CHECK_EN (expected/mismatch) exist only when that
// macro is defined.
interface div3_recon_if #(
  parameter int SIZE = 20
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] quotient;
  logic [1:0]      reminder;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE+1:0] dividend;
  logic            rem_err;
`ifdef DIV3_RECON_CHECK_EN
  logic [SIZE-1:0] expected;
  logic            mismatch;

  modport master (
    output in_valid, quotient, reminder, out_ready, expected,
    input  in_ready, out_valid, dividend, rem_err, mismatch
  );

  modport slave (
    input  in_valid, quotient, reminder, out_ready, expected,
    output in_ready, out_valid, dividend, rem_err, mismatch
  );
`else
  modport master (
    output in_valid, quotient, reminder, out_ready,
    input  in_ready, out_valid, dividend, rem_err
  );

  modport slave (
    input  in_valid, quotient, reminder, out_ready,
    output in_ready, out_valid, dividend, rem_err
  );
`endif
endinterface

// File: rtl/div3_recon.sv
// Bit-serial rebuild of dividend = 3*quotient + reminder, LSB first.
// 3q is formed as q + (q << 1), so each step adds q[i], q[i-1] and the carry.
// Optional compare against a reference dividend: define DIV3_RECON_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | producing one result bit per clock, SIZE+2 clocks
// DONE  | result held, out_valid high until out_ready
module div3_recon #(
  parameter int SIZE = 20
) (
  input logic         sys_clock,
  input logic         reset,
  div3_recon_if.slave bus
);
  localparam int CW = $clog2(SIZE + 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [SIZE-1:0] q_sr;
  logic            q_prev;
  logic [1:0]      carry;
  logic [CW-1:0]   bit_cnt;
  logic [SIZE+1:0] result;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            rem_err_r;
  logic [2:0]      bit_sum;
  logic [SIZE+1:0] result_nxt;
`ifdef DIV3_RECON_CHECK_EN
  logic [SIZE-1:0] exp_q;
  logic            mismatch_r;
`endif

  // One column of q + 2q + carry; zero fill of q_sr supplies q[k]=0 past the top.
  always_comb begin
    bit_sum    = {2'b00, q_sr[0]} + {2'b00, q_prev} + {1'b0, carry};
    result_nxt = {bit_sum[0], result[SIZE+1:1]};
  end

  // Sequencer and datapath; outputs are registered and cleared by reset.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      q_sr        <= '0;
      q_prev      <= 1'b0;
      carry       <= 2'd0;
      bit_cnt     <= '0;
      result      <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      rem_err_r   <= 1'b0;
`ifdef DIV3_RECON_CHECK_EN
      exp_q       <= '0;
      mismatch_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            q_sr       <= bus.quotient;
            q_prev     <= 1'b0;
            carry      <= bus.reminder;
            bit_cnt    <= '0;
            result     <= '0;
            rem_err_r  <= (bus.reminder == 2'd3);
            in_ready_r <= 1'b0;
            state      <= RUN;
`ifdef DIV3_RECON_CHECK_EN
            exp_q      <= bus.expected;
`endif
          end
        end
        RUN: begin
          q_sr    <= q_sr >> 1;
          q_prev  <= q_sr[0];
          carry   <= bit_sum[2:1];
          result  <= result_nxt;
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == LAST_BIT) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
`ifdef DIV3_RECON_CHECK_EN
            mismatch_r  <= (result_nxt != {2'b00, exp_q});
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.dividend  = result;
  assign bus.rem_err   = rem_err_r;
`ifdef DIV3_RECON_CHECK_EN
  assign bus.mismatch  = mismatch_r;
`endif
endmodule
